mem_stream_reader: RTL and testbench

- Read-side sequencer that sits directly upstream of consumers of the dual-port coefficient RAM.
- Drives one RAM port, with write enable tied low, to fetch LEN consecutive words starting at BASE.
- Absorbs the RAM's fixed 1-cycle read latency and presents the words as a valid/ready stream with full backpressure support.
- ROLLO-II encrypt datapath stages (multiplier, adder) use it to stream polynomial coefficients out of RAM.

---
 rtl/mem_stream_reader.sv | 137 +++++++++++++
 tb/tb_mem_stream_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: fetches len consecutive words from one RAM port starting at base
//   and streams them out over valid/ready.
// Latency: start accepted at edge T -> first mem_en in cycle T+1 -> first out_valid in T+3;
//   1 word/cycle with out_ready held high.
// Backpressure: reads are issued only when the 2-entry FIFO is sure to have room for the
//   returning word, so any out_ready pattern is absorbed without loss.
// Optional build macro MSR_REVERSE_EN: addresses descend from base (0 wraps to DEPTH-1).
// Ports: clk/rst_n (sync active-low); start/base/len request (sampled in IDLE);
//   busy/done status; mem_en/mem_we/mem_addr/mem_dout RAM port;
//   out_data/out_valid/out_ready output stream.
module mem_stream_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base,
  input  logic [AW:0]      len,
  output logic             busy,
  output logic             done,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_dout,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    addr_q, addr_next;
  logic [AW:0]      len_q, issued, len_clamped;
  logic             inflight;
  logic [WIDTH-1:0] fifo_mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       fifo_cnt;
  logic             push, pop, space;
  logic [2:0]       occ_after;

  assign len_clamped = (len > DEPTH_W) ? DEPTH_W : len;

  // Wrap at DEPTH-1 rather than at 2^AW-1 so non-power-of-two RAMs work.
  always_comb begin
    addr_next = addr_q;
`ifdef MSR_REVERSE_EN
    addr_next = (addr_q == '0) ? LAST_ADDR : addr_q - AW'(1);
`else
    addr_next = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
`endif
  end

  // FIFO occupancy at the end of this cycle, counting the word already in flight.
  // A new read is allowed only if that leaves a free slot for its data.
  assign push      = inflight;
  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid & out_ready;
  assign occ_after = {1'b0, fifo_cnt} + {2'b0, push} - {2'b0, pop};
  assign space     = (occ_after < 3'd2);

  assign out_data = out_valid ? fifo_mem[rd_ptr] : '0;
  assign mem_we   = 1'b0;
  assign mem_addr = addr_q;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len_clamped == '0) ? FIN : RUN;
      RUN:     if (mem_en && ((issued + (AW+1)'(1)) == len_q)) state_nxt = DRAIN;
      DRAIN:   if (!inflight && (occ_after == 3'd0)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    mem_en = 1'b0;
    case (state)
      RUN: begin
        busy   = 1'b1;
        mem_en = space;
      end
      DRAIN:   busy = 1'b1;
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  // Address/count sequencing and FIFO control. Clearing inflight on reset
  // drops any word the RAM returns right after an aborted transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      len_q    <= '0;
      issued   <= '0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      inflight <= mem_en;
      if (state == IDLE && start) begin
        addr_q <= base;
        len_q  <= len_clamped;
        issued <= '0;
      end else if (mem_en) begin
        addr_q <= addr_next;
        issued <= issued + (AW+1)'(1);
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= occ_after[1:0];
    end
  end

  // Storage needs no reset: out_data is gated while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_dout;
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader: DEPTH=64 main instance plus a DEPTH=48
// instance for the non-power-of-two wrap. Words popped, addresses issued and
// done pulses are logged on the falling edge and compared with hand-derived values.
module tb_mem_stream_reader;

  localparam int W = 8;
  localparam int D = 64;
  localparam int A = 6;
  localparam int DB = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, busy, done, mem_en, mem_we, out_valid, out_ready;
  logic [A-1:0] base, mem_addr;
  logic [A:0]   len;
  logic [W-1:0] mem_dout, out_data;
  logic [W-1:0] ram [D];

  logic         start_b, busy_b, done_b, mem_en_b, mem_we_b, out_valid_b, rdy_b;
  logic [A-1:0] base_b, mem_addr_b;
  logic [A:0]   len_b;
  logic [W-1:0] mem_dout_b, out_data_b;
  logic [W-1:0] ram_b [DB];

  mem_stream_reader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mem_stream_reader #(.WIDTH(W), .DEPTH(DB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .base(base_b), .len(len_b),
    .busy(busy_b), .done(done_b), .mem_en(mem_en_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_dout(mem_dout_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(rdy_b)
  );

  // 1-cycle-latency RAM models
  always @(posedge clk) if (mem_en)   mem_dout   <= ram[mem_addr];
  always @(posedge clk) if (mem_en_b) mem_dout_b <= ram_b[mem_addr_b];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Backpressure pattern 1,0,0 repeating
  logic bp = 1'b0;
  int   bp_ph = 0;
  always @(posedge clk) begin
    #1;
    if (bp) begin
      out_ready = (bp_ph == 0);
      bp_ph = (bp_ph == 2) ? 0 : bp_ph + 1;
    end
  end

  int   pops[$];
  int   addrs[$];
  int   pops_b[$];
  int   done_cnt, done_cyc, first_en, first_vld, stall_err, max_cnt, busy_hi;
  logic prev_stall = 1'b0;
  logic [W-1:0] prev_data;

  always @(negedge clk) begin
    if (out_valid && out_ready) pops.push_back(int'(out_data));
    if (out_valid_b && rdy_b)   pops_b.push_back(int'(out_data_b));
    if (mem_en) begin
      addrs.push_back(int'(mem_addr));
      if (first_en < 0) first_en = cyc;
    end
    if (out_valid && first_vld < 0) first_vld = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_hi++;
    if (prev_stall && (!out_valid || out_data != prev_data)) stall_err++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (int'(dut.fifo_cnt) > max_cnt) max_cnt = int'(dut.fifo_cnt);
  end

  task automatic clear_log();
    pops.delete();
    addrs.delete();
    pops_b.delete();
    done_cnt = 0; done_cyc = -1; first_en = -1; first_vld = -1;
    stall_err = 0; max_cnt = 0; busy_hi = 0;
  endtask

  // Returns t = cyc value of the cycle right after the accepting edge (cycle T+1).
  task automatic do_start(input int b, input int l, output int t);
    @(posedge clk); #1;
    start = 1'b1; base = A'(b); len = (A+1)'(l);
    @(posedge clk); #1;
    start = 1'b0;
    t = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string tag, input int got[$], input int exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_mem_en"}, int'(mem_en), 0);
    check({tag, "_mem_addr"}, int'(mem_addr), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
  endtask

  initial begin
    int t;
    int mism, dups;
    logic [D-1:0] seen;

    for (int i = 0; i < D; i++)  ram[i]   = W'(i);
    for (int i = 0; i < DB; i++) ram_b[i] = W'(i);
    rst_n = 1'b0; start = 1'b0; base = '0; len = '0; out_ready = 1'b1;
    start_b = 1'b0; base_b = '0; len_b = '0; rdy_b = 1'b1;
    clear_log();

    idle(2);
    check_idle_outputs("rst");
    check("rst_mem_we", int'(mem_we), 0);
    rst_n = 1'b1;
    idle(2);

`ifdef MSR_REVERSE_EN
    clear_log();
    do_start(1, 4, t);
    idle(12);
    check_seq("rev_data", pops, '{1, 0, 63, 62});
    check_seq("rev_addr", addrs, '{1, 0, 63, 62});
    check("rev_first_vld", first_vld, t + 2);
    check("rev_done_cnt", done_cnt, 1);
    check("rev_done_cyc", done_cyc, t + 6);
`else
    // 1: basic fetch and latency
    clear_log();
    do_start(5, 4, t);
    idle(12);
    check_seq("t1_data", pops, '{5, 6, 7, 8});
    check("t1_first_en", first_en, t);
    check("t1_first_vld", first_vld, t + 2);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_done_cyc", done_cyc, t + 6);
    check("t1_busy_cycles", busy_hi, 6);
    check("t1_busy_after", int'(busy), 0);

    // 2: wrap at 2^AW and at a non-power-of-two depth
    clear_log();
    do_start(62, 4, t);
    idle(12);
    check_seq("t2_data", pops, '{62, 63, 0, 1});
    check_seq("t2_addr", addrs, '{62, 63, 0, 1});

    clear_log();
    @(posedge clk); #1;
    start_b = 1'b1; base_b = 6'd46; len_b = 7'd4;
    @(posedge clk); #1;
    start_b = 1'b0;
    idle(12);
    check_seq("t2_d48", pops_b, '{46, 47, 0, 1});

    // 3: backpressure
    clear_log();
    bp_ph = 0;
    bp = 1'b1;
    do_start(0, 8, t);
    idle(40);
    bp = 1'b0;
    idle(1);
    out_ready = 1'b1;
    check_seq("t3_data", pops, '{0, 1, 2, 3, 4, 5, 6, 7});
    check("t3_max_cnt_le2", int'(max_cnt <= 2), 1);
    check("t3_stall_stable", stall_err, 0);
    check("t3_done_cnt", done_cnt, 1);

    // 4: len=0, then a full-depth and an over-depth (clamped) transfer
    clear_log();
    do_start(7, 0, t);
    idle(5);
    check("t4_zero_mem_en", addrs.size(), 0);
    check("t4_zero_vld", first_vld, -1);
    check("t4_zero_done_cnt", done_cnt, 1);
    check("t4_zero_done_cyc", done_cyc, t);
    check("t4_zero_busy", busy_hi, 0);

    clear_log();
    do_start(20, 64, t);
    idle(80);
    mism = 0; dups = 0; seen = '0;
    for (int i = 0; i < pops.size(); i++) if (pops[i] != (20 + i) % 64) mism++;
    foreach (addrs[i]) begin
      if (seen[addrs[i]]) dups++;
      seen[addrs[i]] = 1'b1;
    end
    check("t4_full_len", pops.size(), 64);
    check("t4_full_order", mism, 0);
    check("t4_full_addr_cnt", addrs.size(), 64);
    check("t4_full_dups", dups, 0);
    check("t4_full_done_cyc", done_cyc, t + 66);

    clear_log();
    do_start(0, 70, t);
    idle(80);
    check("t4_clamp_len", pops.size(), 64);
    check("t4_clamp_done_cyc", done_cyc, t + 66);

    // 5: reset mid-transfer, restart, start while busy
    clear_log();
    do_start(0, 10, t);
    for (int k = 0; k < 20 && pops.size() < 3; k++) idle(1);
    check("t5_popped_3", pops.size(), 3);
    rst_n = 1'b0;
    idle(1);
    check_idle_outputs("t5_rst");
    rst_n = 1'b1;
    idle(3);
    clear_log();
    do_start(10, 2, t);
    start = 1'b1; base = 6'd30; len = 7'd5;
    check("t5_busy_at_2nd_start", int'(busy), 1);
    idle(1);
    start = 1'b0;
    idle(12);
    check_seq("t5_data", pops, '{10, 11});
    check("t5_addr_cnt", addrs.size(), 2);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_busy_after", int'(busy), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
